// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the motor position sequencer: FSM states,
// fault codes, position range and duty width.
package motor_ctrl_pkg;

  localparam int unsigned POS_MAX  = 720;
  localparam int unsigned HOME_POS = 360;
  localparam int unsigned DUTY_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOME,
    S_MOVE,
    S_BRAKE,
    S_DONE,
    S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    F_NONE       = 3'd0,
    F_BAD_TARGET = 3'd1,
    F_STALL      = 3'd2,
    F_LIMIT      = 3'd3,
    F_OVERSHOOT  = 3'd4
  } fault_t;

  function automatic logic [32:0] abs33(input logic [32:0] v);
    return v[32] ? (~v + 33'd1) : v;
  endfunction

endpackage

// File: rtl/ctrl_timer.sv
// Loadable 32-bit down-counter; holds at zero and flags expiry there.
module ctrl_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        run,
  output logic        expired
);

  logic [31:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (run && (count != '0)) begin
      count <= count - 32'd1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/motor_position_sequencer.sv
// Closed-loop move controller: IDLE/HOME/MOVE/BRAKE/DONE/FAULT sequencing of
// motor enable, direction and duty from encoder position, with sticky fault codes.
module motor_position_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned       DEADBAND      = 2,
  parameter int unsigned       SLOW_ZONE     = 20,
  parameter logic [DUTY_W-1:0] DUTY_FAST     = 8'd200,
  parameter logic [DUTY_W-1:0] DUTY_SLOW     = 8'd80,
  parameter int unsigned       BRAKE_CYCLES  = 1_000_000,
  parameter int unsigned       STALL_CYCLES  = 30_000_000,
  parameter int unsigned       MAX_REVERSALS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_home,
  input  logic [9:0]        cmd_target,
  input  logic              abort,
  input  logic              fault_clr,
  input  logic [31:0]       enc_position,
  input  logic              enc_position_error,
  input  logic [31:0]       enc_rpm,
  output logic              enc_position_rst,
  output logic              motor_en,
  output logic              motor_dir,
  output logic [DUTY_W-1:0] motor_duty,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [2:0]        fault_code
);

  localparam logic [32:0] DEADBAND_W  = 33'(DEADBAND);
  localparam logic [32:0] SLOW_ZONE_W = 33'(SLOW_ZONE);
  localparam logic [31:0] BRAKE_LOAD  = 32'(BRAKE_CYCLES - 1);
  localparam logic [31:0] STALL_LAST  = 32'(STALL_CYCLES - 1);
  localparam logic [31:0] REV_MAX     = 32'(MAX_REVERSALS);
  localparam logic [9:0]  POS_MAX_W   = 10'(POS_MAX);

  state_t state, state_nx;
  fault_t fault_sel, fault_code_q, fault_code_nx;

  logic [9:0]        target_q;
  logic              dir_latched;
  logic              aborted;
  logic [31:0]       stall_cnt;
  logic [31:0]       rev_cnt;

  logic [9:0]        tgt_sel;
  logic signed [32:0] err;
  logic [32:0]       abs_err;
  logic              err_pos;
  logic              in_deadband;
  logic              overshoot;
  logic              cmd_take;
  logic              stall_hit;
  logic              brake_done;
  logic              rev_exceeded;
  logic              overshoot_exit;
  logic              move_entry;
  logic              brake_entry;

  logic              en_nx, dir_nx, pos_rst_nx, done_nx, fault_nx;
  logic [DUTY_W-1:0] duty_nx;

  // In IDLE the command has not been latched yet, so the error is taken from
  // the live target to pick the initial direction and duty.
  assign tgt_sel     = (state == S_IDLE) ? cmd_target : target_q;
  assign err         = $signed({23'd0, tgt_sel}) - $signed({1'b0, enc_position});
  assign abs_err     = abs33(err);
  assign err_pos     = !err[32] && (err != '0);
  assign in_deadband = (abs_err <= DEADBAND_W);
  assign overshoot   = dir_latched ? err[32] : err_pos;

  assign cmd_take     = cmd_valid && (state == S_IDLE);
  assign stall_hit    = (stall_cnt == STALL_LAST);
  // Counts overshoots so far; each of the first MAX_REVERSALS earns a correction.
  assign rev_exceeded = (rev_cnt > REV_MAX);

  assign overshoot_exit = (state == S_MOVE) && !abort && !enc_position_error &&
                          !stall_hit && !in_deadband && overshoot;
  assign move_entry     = (state_nx == S_MOVE) && (state != S_MOVE);
  assign brake_entry    = (state_nx == S_BRAKE) && (state != S_BRAKE);

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE) && (state != S_FAULT);

  ctrl_timer u_brake_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (brake_entry),
    .load_val (BRAKE_LOAD),
    .run      (state == S_BRAKE),
    .expired  (brake_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    fault_sel = F_NONE;
    case (state)
      S_IDLE: begin
        if (cmd_take) begin
          if (cmd_home) begin
            state_nx = S_HOME;
          end else if (cmd_target > POS_MAX_W) begin
            state_nx  = S_FAULT;
            fault_sel = F_BAD_TARGET;
          end else begin
            state_nx = S_MOVE;
          end
        end
      end
      S_HOME: state_nx = S_DONE;
      S_MOVE: begin
        if (abort) begin
          state_nx = S_BRAKE;
        end else if (enc_position_error) begin
          state_nx  = S_FAULT;
          fault_sel = F_LIMIT;
        end else if (stall_hit) begin
          state_nx  = S_FAULT;
          fault_sel = F_STALL;
        end else if (in_deadband || overshoot) begin
          state_nx = S_BRAKE;
        end
      end
      S_BRAKE: begin
        if (brake_done) begin
          if (aborted) begin
            state_nx = S_IDLE;
          end else if (in_deadband) begin
            state_nx = S_DONE;
          end else if (rev_exceeded) begin
            state_nx  = S_FAULT;
            fault_sel = F_OVERSHOOT;
          end else begin
            state_nx = S_MOVE;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      S_FAULT: if (fault_clr) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    en_nx         = 1'b0;
    duty_nx       = '0;
    dir_nx        = motor_dir;
    pos_rst_nx    = (state_nx == S_HOME);
    done_nx       = (state_nx == S_DONE);
    fault_nx      = (state_nx == S_FAULT);
    fault_code_nx = fault_code_q;
    // Direction only moves together with enable rising or while already
    // driving the same way; BRAKE and FAULT keep the last direction.
    if (state_nx == S_MOVE) begin
      en_nx   = 1'b1;
      dir_nx  = err_pos;
      duty_nx = (abs_err <= SLOW_ZONE_W) ? DUTY_SLOW : DUTY_FAST;
    end
    if ((state_nx == S_FAULT) && (state != S_FAULT)) begin
      fault_code_nx = fault_sel;
    end else if (state_nx == S_IDLE) begin
      fault_code_nx = F_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      motor_en         <= 1'b0;
      motor_dir        <= 1'b0;
      motor_duty       <= '0;
      enc_position_rst <= 1'b0;
      done             <= 1'b0;
      fault            <= 1'b0;
      fault_code_q     <= F_NONE;
    end else begin
      motor_en         <= en_nx;
      motor_dir        <= dir_nx;
      motor_duty       <= duty_nx;
      enc_position_rst <= pos_rst_nx;
      done             <= done_nx;
      fault            <= fault_nx;
      fault_code_q     <= fault_code_nx;
    end
  end

  assign fault_code = fault_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q    <= '0;
      dir_latched <= 1'b0;
      aborted     <= 1'b0;
      rev_cnt     <= '0;
      stall_cnt   <= '0;
    end else begin
      if (cmd_take) begin
        target_q <= cmd_target;
        aborted  <= 1'b0;
      end else if ((state == S_MOVE) && abort) begin
        aborted <= 1'b1;
      end

      if (move_entry) begin
        dir_latched <= err_pos;
      end

      if (cmd_take) begin
        rev_cnt <= '0;
      end else if (overshoot_exit && (rev_cnt != '1)) begin
        rev_cnt <= rev_cnt + 32'd1;
      end

      if (move_entry) begin
        stall_cnt <= '0;
      end else if (state == S_MOVE) begin
        if (enc_rpm != '0) begin
          stall_cnt <= '0;
        end else if (stall_cnt != '1) begin
          stall_cnt <= stall_cnt + 32'd1;
        end
      end
    end
  end

endmodule
